// File: rtl/serial_cmp.sv
// serial_cmp: multi-cycle magnitude comparator.
// Scans two latched operands MSB-first, one bit per clock, using a
// start/busy/done handshake. Supports unsigned and two's complement
// compares, with an optional early exit on the first differing bit.
module serial_cmp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx;
    logic             pend;
    logic             pend_gt;

    logic             a_bit;
    logic             b_bit;
    logic             diff;
    logic             sign_pos;
    logic             dec_gt;

    // Decide "A > B" from the first differing bit: the sign bit of a
    // two's complement compare has inverted weight, all others are unsigned.
    function automatic logic decide_gt(input logic a_b, input logic at_sign);
        return at_sign ? ~a_b : a_b;
    endfunction

    // Current bit pair under inspection and its decision if it differs.
    always_comb begin
        a_bit    = a_q[idx];
        b_bit    = b_q[idx];
        diff     = a_bit ^ b_bit;
        sign_pos = sgn_q && (idx == IW'(WIDTH - 1));
        dec_gt   = decide_gt(a_bit, sign_pos);
    end

    assign busy = (state == S_SCAN);
    assign done = (state == S_DONE);

    // Control FSM, operand latches, scan index and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx     <= '0;
            pend    <= 1'b0;
            pend_gt <= 1'b0;
            lt      <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= num1;
                        b_q     <= num2;
                        sgn_q   <= signed_mode;
                        idx     <= IW'(WIDTH - 1);
                        pend    <= 1'b0;
                        pend_gt <= 1'b0;
                        lt      <= 1'b0;
                        gt      <= 1'b0;
                        eq      <= 1'b0;
                        state   <= S_SCAN;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (EARLY_EXIT && diff) begin
                        gt    <= dec_gt;
                        lt    <= ~dec_gt;
                        state <= S_DONE;
                    end else if (idx == '0) begin
                        // Last bit: a difference recorded earlier wins over bit 0.
                        if (pend) begin
                            gt <= pend_gt;
                            lt <= ~pend_gt;
                        end else if (diff) begin
                            gt <= dec_gt;
                            lt <= ~dec_gt;
                        end else begin
                            eq <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        if (diff && !pend) begin
                            pend    <= 1'b1;
                            pend_gt <= dec_gt;
                        end
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
